// File: rtl/mic_merge.sv
// mic_merge: 2:1 packet-atomic merge of two MIC beat streams onto one output stream.
// Latency: 1 cycle from input accept to O_TVALID; 1 beat/cycle sustained when O_TREADY=1.
// Backpressure: 2-entry output skid (output reg + spare reg); I*_TREADY depends on skid state only, never on O_TREADY.
//
// Ports: clk/reset (async active-high); I0_*/I1_* input streams (TVALID/TREADY/TDATA/TLAST);
//        O_* merged output stream, all outputs registered.
// Build option MIC_MERGE_RR_EN: defined -> round-robin between simultaneous first beats;
//        undefined (default) -> fixed priority, input 0 wins.
module mic_merge #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              I0_TVALID,
    output logic              I0_TREADY,
    input  logic [DATA_W-1:0] I0_TDATA,
    input  logic              I0_TLAST,
    input  logic              I1_TVALID,
    output logic              I1_TREADY,
    input  logic [DATA_W-1:0] I1_TDATA,
    input  logic              I1_TLAST,
    output logic              O_TVALID,
    input  logic              O_TREADY,
    output logic [DATA_W-1:0] O_TDATA,
    output logic              O_TLAST
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    logic [1:0]        state;
    logic              sp_vld;
    logic [DATA_W-1:0] sp_dat;
    logic              sp_last;
    logic              can_accept;
    logic              pick1;
    logic              sel0;
    logic              sel1;
    logic              acc0;
    logic              acc1;
    logic              in_vld;
    logic [DATA_W-1:0] in_dat;
    logic              in_last;

`ifdef MIC_MERGE_RR_EN
    // Input that took the most recent packet; 1 at reset so input 0 goes first.
    logic last_grant;
`endif

    // A new beat is taken only while the spare register is free, so a
    // stalled output beat always has somewhere to park the one behind it.
    assign can_accept = !sp_vld;

    // Which input a packet start in IDLE goes to.
    always_comb begin
        pick1 = 1'b0;
`ifdef MIC_MERGE_RR_EN
        if (I0_TVALID && I1_TVALID)
            pick1 = !last_grant;
        else
            pick1 = I1_TVALID;
`else
        pick1 = I1_TVALID && !I0_TVALID;
`endif
    end

    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        case (state)
            ST_IDLE: begin
                sel0 = I0_TVALID && !pick1;
                sel1 = pick1;
            end
            ST_OWN0: sel0 = 1'b1;
            ST_OWN1: sel1 = 1'b1;
            default: begin
                sel0 = 1'b0;
                sel1 = 1'b0;
            end
        endcase
    end

    // Ready held low during reset so no beat is taken while state is cleared.
    assign I0_TREADY = sel0 && can_accept && !reset;
    assign I1_TREADY = sel1 && can_accept && !reset;

    assign acc0    = I0_TVALID && I0_TREADY;
    assign acc1    = I1_TVALID && I1_TREADY;
    assign in_vld  = acc0 || acc1;
    assign in_dat  = acc1 ? I1_TDATA : I0_TDATA;
    assign in_last = acc1 ? I1_TLAST : I0_TLAST;

    // Ownership FSM: an input keeps the output from its first accepted beat
    // until its TLAST beat is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
`ifdef MIC_MERGE_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (acc0) begin
`ifdef MIC_MERGE_RR_EN
                        last_grant <= 1'b0;
`endif
                        if (!I0_TLAST)
                            state <= ST_OWN0;
                    end else if (acc1) begin
`ifdef MIC_MERGE_RR_EN
                        last_grant <= 1'b1;
`endif
                        if (!I1_TLAST)
                            state <= ST_OWN1;
                    end
                end
                ST_OWN0: if (acc0 && I0_TLAST) state <= ST_IDLE;
                ST_OWN1: if (acc1 && I1_TLAST) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output skid. Stalled output: hold it and park any new beat in the spare.
    // Otherwise the spare (oldest) drains first; an accept cannot happen in
    // that cycle since the spare was occupied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            O_TVALID <= 1'b0;
            O_TDATA  <= '0;
            O_TLAST  <= 1'b0;
            sp_vld   <= 1'b0;
            sp_dat   <= '0;
            sp_last  <= 1'b0;
        end else if (O_TVALID && !O_TREADY) begin
            if (in_vld) begin
                sp_vld  <= 1'b1;
                sp_dat  <= in_dat;
                sp_last <= in_last;
            end
        end else if (sp_vld) begin
            O_TVALID <= 1'b1;
            O_TDATA  <= sp_dat;
            O_TLAST  <= sp_last;
            sp_vld   <= 1'b0;
        end else begin
            O_TVALID <= in_vld;
            if (in_vld) begin
                O_TDATA <= in_dat;
                O_TLAST <= in_last;
            end
        end
    end

endmodule

// File: tb/tb_mic_merge.sv
// tb_mic_merge: scoreboard bench for mic_merge (reset, latency, backpressure,
// mid-packet reset, contention order, packet ownership during input stall).
// Input 1 beats carry bit 63 set so the output side can tell the source.
module tb_mic_merge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i0_vld = 1'b0, i0_last = 1'b0, i1_vld = 1'b0, i1_last = 1'b0;
    logic [63:0] i0_dat = '0, i1_dat = '0;
    logic        i0_rdy, i1_rdy;
    logic        o_vld, o_last;
    logic        o_rdy = 1'b1;
    logic [63:0] o_dat;

    always #5 clk = ~clk;

    mic_merge #(.DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .I0_TVALID(i0_vld), .I0_TREADY(i0_rdy), .I0_TDATA(i0_dat), .I0_TLAST(i0_last),
        .I1_TVALID(i1_vld), .I1_TREADY(i1_rdy), .I1_TDATA(i1_dat), .I1_TLAST(i1_last),
        .O_TVALID(o_vld), .O_TREADY(o_rdy), .O_TDATA(o_dat), .O_TLAST(o_last)
    );

    int          total = 0, bad = 0, cyc = 0;
    logic [64:0] q0[$], q1[$];
    int          acc0_cyc[$];
    bit          pkt_src[$], exp_src[$];
    bit          mon_en = 0, lat_chk = 0, bp = 0, own_chk = 0, mid0 = 0;
    bit          in_pkt = 0, cur_src = 0, hold = 0, s;
    logic [64:0] held, e;
    int          a;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) o_rdy = bp ? ~o_rdy : 1'b1;

    // Output monitor, sampled 1 ns before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (mon_en) begin
            if (own_chk && mid0) chk("own_i1_rdy", 65'(i1_rdy), 65'(0));
            if (hold) begin
                chk("stall_vld", 65'(o_vld), 65'(1));
                chk("stall_dat", {o_last, o_dat}, held);
            end
            hold = o_vld && !o_rdy;
            held = {o_last, o_dat};
            if (o_vld && o_rdy) begin
                s = o_dat[63];
                if (in_pkt) chk("interleave", 65'(s), 65'(cur_src));
                else pkt_src.push_back(s);
                cur_src = s;
                in_pkt  = !o_last;
                if (s == 1'b0 && q0.size() > 0) e = q0.pop_front();
                else if (s == 1'b1 && q1.size() > 0) e = q1.pop_front();
                else e = 'x;
                chk("beat", {o_last, o_dat}, e);
                if (lat_chk && s == 1'b0) begin
                    a = (acc0_cyc.size() > 0) ? acc0_cyc.pop_front() : -100;
                    chk("latency", 65'(cyc - a), 65'(1));
                end
            end
        end
    end

    // Drive one packet on input p; called at a falling edge, returns at one.
    task automatic send(input bit p, input logic [63:0] base, input logic [63:0] step,
                        input int n, input int stall_at, input int stall_len, input bit keep);
        logic [63:0] d;
        bit          l, hs;
        int          t;
        for (int i = 0; i < n; i++) begin
            d = base + 64'(i) * step;
            l = (i == n - 1);
            if (i == stall_at) begin
                if (p) i1_vld = 1'b0; else i0_vld = 1'b0;
                repeat (stall_len) @(negedge clk);
            end
            if (p) begin
                i1_vld = 1'b1; i1_dat = d; i1_last = l; q1.push_back({l, d});
            end else begin
                i0_vld = 1'b1; i0_dat = d; i0_last = l; q0.push_back({l, d});
            end
            hs = 1'b0;
            t  = 0;
            while (!hs && t < 100) begin
                #4;
                hs = p ? i1_rdy : i0_rdy;
                if (hs && !p) begin
                    if (lat_chk) acc0_cyc.push_back(cyc);
                    if (i == 0 && !l) mid0 = 1'b1;
                    if (l) mid0 = 1'b0;
                end
                @(negedge clk);
                t++;
            end
            if (!hs) begin
                chk("accept_timeout", 65'(0), 65'(1));
                break;
            end
        end
        if (!keep) begin
            if (p) begin i1_vld = 1'b0; i1_last = 1'b0; end
            else begin i0_vld = 1'b0; i0_last = 1'b0; end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 65'(q0.size() + q1.size()), 65'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic cmp_src(input string tag);
        chk({tag, "_npkt"}, 65'(pkt_src.size()), 65'(exp_src.size()));
        for (int i = 0; i < exp_src.size() && i < pkt_src.size(); i++)
            chk({tag, "_src"}, 65'(pkt_src[i]), 65'(exp_src[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 2 cycles with both inputs requesting: no ready, no output.
        reset = 1'b1; i0_vld = 1'b1; i1_vld = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #4;
            chk("rst_o_vld", 65'(o_vld), 65'(0));
            chk("rst_i0_rdy", 65'(i0_rdy), 65'(0));
            chk("rst_i1_rdy", 65'(i1_rdy), 65'(0));
        end
        @(negedge clk);
        reset = 1'b0; i0_vld = 1'b0; i1_vld = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Single input, 3 beats, 1-cycle latency, back-to-back.
        lat_chk = 1'b1;
        send(0, 64'h11, 64'h11, 3, -1, 0, 0);
        drain();
        lat_chk = 1'b0;

        // Output backpressure toggling every cycle, 8-beat packet.
        bp = 1'b1;
        send(0, 64'h100, 64'h1, 8, -1, 0, 0);
        drain();
        bp = 1'b0;
        @(negedge clk);

        // Reset in the middle of an input-0 packet.
        mon_en = 1'b0;
        i0_vld = 1'b1; i0_dat = 64'h55; i0_last = 1'b0;
        @(negedge clk);
        i0_vld = 1'b0;
        chk("mid_pre_o_vld", 65'(o_vld), 65'(1));
        reset = 1'b1;
        #1;
        chk("mid_rst_o_vld", 65'(o_vld), 65'(0));
        @(negedge clk);
        reset = 1'b0;
        i1_vld = 1'b1; i1_dat = 64'h8000_0000_0000_0077; i1_last = 1'b1;
        #4;
        chk("mid_rst_i1_rdy", 65'(i1_rdy), 65'(1));
        @(negedge clk);
        i1_vld = 1'b0; i1_last = 1'b0;
        repeat (3) @(negedge clk);
        in_pkt = 1'b0; hold = 1'b0;
        mon_en = 1'b1;

        // Contention: both inputs stream three 2-beat packets back to back.
        pkt_src.delete();
        exp_src.delete();
        fork
            for (int k = 0; k < 3; k++)
                send(0, 64'h1000 + 64'(k) * 64'h10, 64'h1, 2, -1, 0, k < 2);
            for (int k = 0; k < 3; k++)
                send(1, 64'h8000_0000_0000_2000 + 64'(k) * 64'h10, 64'h1, 2, -1, 0, k < 2);
        join
        drain();
`ifdef MIC_MERGE_RR_EN
        exp_src = '{0, 1, 0, 1, 0, 1};
`else
        exp_src = '{0, 0, 0, 1, 1, 1};
`endif
        cmp_src("contend");

        // Ownership: input 0 stalls mid-packet while input 1 waits.
        pkt_src.delete();
        own_chk = 1'b1;
        fork
            send(0, 64'h3000, 64'h1, 4, 2, 5, 0);
            begin
                repeat (2) @(negedge clk);
                send(1, 64'h8000_0000_0000_4000, 64'h1, 2, -1, 0, 0);
            end
        join
        drain();
        own_chk = 1'b0;
        exp_src = '{0, 1};
        cmp_src("owner");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
